// File: rtl/wb_trace_fifo_pkg.sv
// Shared record layout for the writeback trace path: field widths, bit offsets and record width.
// Record width grows by the timestamp field when WB_TRACE_TIMESTAMP_EN is defined.
package wb_trace_fifo_pkg;

   localparam int TRACE_PC_W   = 32;
   localparam int TRACE_WNUM_W = 5;
   localparam int TRACE_DATA_W = 32;
   localparam int TRACE_TS_W   = 32;

   // Field offsets so the sink and any checker unpack records identically.
   localparam int TRACE_WDATA_LSB = 0;
   localparam int TRACE_WNUM_LSB  = TRACE_WDATA_LSB + TRACE_DATA_W;
   localparam int TRACE_PC_LSB    = TRACE_WNUM_LSB + TRACE_WNUM_W;
   localparam int TRACE_TS_LSB    = TRACE_PC_LSB + TRACE_PC_W;

   localparam int TRACE_BASE_W = TRACE_PC_W + TRACE_WNUM_W + TRACE_DATA_W;

`ifdef WB_TRACE_TIMESTAMP_EN
   localparam int TRACE_REC_W = TRACE_TS_W + TRACE_BASE_W;
`else
   localparam int TRACE_REC_W = TRACE_BASE_W;
`endif

   typedef struct packed {
      logic [TRACE_PC_W-1:0]   pc;
      logic [TRACE_WNUM_W-1:0] wnum;
      logic [TRACE_DATA_W-1:0] wdata;
   } trace_rec_t;

endpackage

// File: rtl/wb_trace_fifo_sync_fifo.sv
// Synchronous FIFO with an occupancy counter and a registered head entry.
// A push into an empty FIFO shows at the head on the next cycle; there is no bypass.
module trace_sync_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic             push_ok;
   logic             pop_ok;
   logic [AW:0]      level_after_pop;

   assign full            = (level == (AW+1)'(DEPTH));
   assign empty           = (level == '0);
   assign pop_ok          = pop && !empty;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign push_ok         = push && (!full || pop_ok);
   assign rd_ptr_nxt      = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
   assign level_after_pop = level - {{AW{1'b0}}, pop_ok};

   always_ff @(posedge clk) begin
      if (push_ok && !clr)
         mem[wr_ptr] <= wdata;
   end

   // When the FIFO is empty after this cycle's pop, the new head is the record being written now.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         head   <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         level  <= level_after_pop + {{AW{1'b0}}, push_ok};
         if (push_ok && level_after_pop == '0)
            head <= wdata;
         else if (pop_ok)
            head <= mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures CPU writeback commits into a trace FIFO drained over valid/ready; never stalls the core.
// Optional feature macro: WB_TRACE_TIMESTAMP_EN prepends a 32-bit free-running cycle stamp.
module wb_trace_fifo
   import wb_trace_fifo_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int DROP_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             debug_wb_pc,
   input  logic [3:0]              debug_wb_rf_we,
   input  logic [4:0]              debug_wb_rf_wnum,
   input  logic [31:0]             debug_wb_rf_wdata,
   input  logic                    trace_clr,
   output logic                    trace_valid,
   input  logic                    trace_ready,
   output logic [TRACE_REC_W-1:0]  trace_data,
   output logic [AW:0]             trace_level,
   output logic                    overflow,
   output logic [DROP_W-1:0]       drop_cnt
);

   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   fifo_full;
   logic                   fifo_empty;
   trace_rec_t             base_rec;
   logic [TRACE_REC_W-1:0] rec;

   assign push        = |debug_wb_rf_we;
   assign pop         = trace_valid & trace_ready;
   assign trace_valid = !fifo_empty;
   assign drop        = push && fifo_full && !pop && !trace_clr;

   assign base_rec.pc    = debug_wb_pc;
   assign base_rec.wnum  = debug_wb_rf_wnum;
   assign base_rec.wdata = debug_wb_rf_wdata;

`ifdef WB_TRACE_TIMESTAMP_EN
   logic [TRACE_TS_W-1:0] ts;

   // Free-running stamp; trace_clr intentionally leaves it alone so stamps stay monotonic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ts <= '0;
      else
         ts <= ts + 1'b1;
   end

   assign rec = {ts, base_rec};
`else
   assign rec = base_rec;
`endif

   trace_sync_fifo #(
      .WIDTH (TRACE_REC_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .clr   (trace_clr),
      .wdata (rec),
      .head  (trace_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (trace_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (trace_clr) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed scenarios plus randomized traffic against a queue model.
// Honors WB_TRACE_TIMESTAMP_EN so the expected records carry the cycle stamp when it is enabled.
module tb_wb_trace_fifo;
   import wb_trace_fifo_pkg::*;

   localparam int DEPTH  = 16;
   localparam int AW     = 4;
   localparam int DROP_W = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [31:0]            debug_wb_pc = '0;
   logic [3:0]             debug_wb_rf_we = '0;
   logic [4:0]             debug_wb_rf_wnum = '0;
   logic [31:0]            debug_wb_rf_wdata = '0;
   logic                   trace_clr = 1'b0;
   logic                   trace_valid;
   logic                   trace_ready = 1'b0;
   logic [TRACE_REC_W-1:0] trace_data;
   logic [AW:0]            trace_level;
   logic                   overflow;
   logic [DROP_W-1:0]      drop_cnt;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_we    (debug_wb_rf_we),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata),
      .trace_clr         (trace_clr),
      .trace_valid       (trace_valid),
      .trace_ready       (trace_ready),
      .trace_data        (trace_data),
      .trace_level       (trace_level),
      .overflow          (overflow),
      .drop_cnt          (drop_cnt)
   );

   // Reference model: a plain queue of expected records plus drop bookkeeping.
   logic [TRACE_REC_W-1:0] model_q [$];
   int                     model_drops = 0;
   bit                     model_ovf = 1'b0;
`ifdef WB_TRACE_TIMESTAMP_EN
   int unsigned            cyc = 0;
`endif
   int                     checks = 0;
   int                     failures = 0;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compareState();
      checkOutput("level", 128'(trace_level), 128'(model_q.size()));
      checkOutput("valid", 128'(trace_valid), 128'(model_q.size() != 0));
      if (model_q.size() != 0)
         checkOutput("data", 128'(trace_data), 128'(model_q[0]));
      checkOutput("overflow", 128'(overflow), 128'(model_ovf));
      checkOutput("drop_cnt", 128'(drop_cnt), 128'(model_drops));
   endtask

   // Drive one cycle of inputs, advance the model at the clock edge, then check all outputs.
   task automatic applyStimulus(input logic [3:0] we, input logic [31:0] pc, input logic [4:0] wnum,
                                input logic [31:0] wdata, input logic ready, input logic clr);
      logic [TRACE_REC_W-1:0] rec;
      debug_wb_rf_we    = we;
      debug_wb_pc       = pc;
      debug_wb_rf_wnum  = wnum;
      debug_wb_rf_wdata = wdata;
      trace_ready       = ready;
      trace_clr         = clr;
      @(posedge clk);
`ifdef WB_TRACE_TIMESTAMP_EN
      rec = {cyc[31:0], pc, wnum, wdata};
      cyc++;
`else
      rec = {pc, wnum, wdata};
`endif
      if (clr) begin
         model_q.delete();
         model_drops = 0;
         model_ovf   = 1'b0;
      end else begin
         if (model_q.size() > 0 && ready)
            void'(model_q.pop_front());
         if (we != 4'd0) begin
            if (model_q.size() < DEPTH)
               model_q.push_back(rec);
            else begin
               model_ovf = 1'b1;
               if (model_drops < (1 << DROP_W) - 1)
                  model_drops++;
            end
         end
      end
      #1;
      compareState();
   endtask

   task automatic randomPush(input logic ready);
      applyStimulus(4'($urandom_range(1, 15)), $urandom, 5'($urandom_range(0, 31)), $urandom, ready, 1'b0);
   endtask

   task automatic idle(input logic ready);
      applyStimulus(4'd0, $urandom, 5'($urandom_range(0, 31)), $urandom, ready, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_level", 128'(trace_level), 128'd0);
      checkOutput("rst_valid", 128'(trace_valid), 128'd0);
      checkOutput("rst_data", 128'(trace_data), 128'd0);
      checkOutput("rst_overflow", 128'(overflow), 128'd0);
      checkOutput("rst_drop", 128'(drop_cnt), 128'd0);
      rst_n = 1'b1;

      $display("[TB] single push with ready high");
      applyStimulus(4'b0001, 32'h1c000000, 5'd5, 32'hdeadbeef, 1'b1, 1'b0);
      idle(1'b1);

      $display("[TB] fill to full and overflow with ready low");
      for (int i = 0; i < 17; i++)
         randomPush(1'b0);

      $display("[TB] push and pop together while full");
      for (int i = 0; i < 3; i++)
         randomPush(1'b1);

      $display("[TB] hold head with ready low, then drain");
      for (int i = 0; i < 5; i++)
         idle(1'b0);
      for (int i = 0; i < 16; i++)
         idle(1'b1);

      $display("[TB] clear with a concurrent push");
      for (int i = 0; i < 7; i++)
         randomPush(1'b0);
      applyStimulus(4'b1000, $urandom, 5'd3, $urandom, 1'b0, 1'b1);
      idle(1'b0);

      $display("[TB] asynchronous reset mid-drain");
      for (int i = 0; i < 9; i++)
         randomPush(1'b0);
      idle(1'b1);
      #2;
      rst_n       = 1'b0;
      trace_ready = 1'b0;
      #1;
      checkOutput("async_valid", 128'(trace_valid), 128'd0);
      checkOutput("async_level", 128'(trace_level), 128'd0);
      model_q.delete();
      model_drops = 0;
      model_ovf   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`ifdef WB_TRACE_TIMESTAMP_EN
      cyc = 0;
`endif
      for (int i = 0; i < 3; i++)
         idle(1'b0);
      randomPush(1'b1);
      idle(1'b1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         logic [3:0] we;
         logic       ready;
         logic       clr;
         we    = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'd0;
         ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         clr   = ($urandom_range(0, 79) == 0);
         applyStimulus(we, $urandom, 5'($urandom_range(0, 31)), $urandom, ready, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
